// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the ALU interface in the multi-cycle datapath. Accepts one
// decoded MIPS instruction per request, drives ALUCtrl/BusA/BusB into the
// combinational ALU, holds them for SETTLE cycles, then captures BusW/Zero
// into a registered response held until the consumer takes it.
//
// Parameters
//   SETTLE      cycles the ALU inputs are held before sampling (1..15)
// Ports
//   CLK, Reset                  clock (rising edge), async active-high reset
//   ReqValid/ReqReady           request handshake (ReqReady only in IDLE)
//   Opcode, Funct, Shamt, Imm   instruction fields
//   RsData, RtData              register operands
//   ALUCtrl, BusA, BusB         registered ALU op code and operands
//   BusW, Zero                  ALU result and zero flag
//   RespValid/RespReady         response handshake
//   Result, ResultZero          captured BusW / Zero
//   IllegalOp                   request did not decode (Result=0)
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int SETTLE = 3
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic [4:0]  Shamt,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    input  logic [15:0] Imm,
    output logic [3:0]  ALUCtrl,
    output logic [31:0] BusA,
    output logic [31:0] BusB,
    input  logic [31:0] BusW,
    input  logic        Zero,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] Result,
    output logic        ResultZero,
    output logic        IllegalOp
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic        legal;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
    } dec_t;

    localparam logic [3:0] LAST_WAIT = 4'(SETTLE - 1);

    state_t     state;
    state_t     stateNext;
    logic [3:0] waitCnt;
    logic       accept;
    dec_t       dec;

    function automatic dec_t decode(input logic [5:0]  op,
                                    input logic [5:0]  fn,
                                    input logic [4:0]  sh,
                                    input logic [31:0] rs,
                                    input logic [31:0] rt,
                                    input logic [15:0] imm);
        dec_t        d;
        logic [31:0] sext;
        logic [31:0] zext;
        sext    = {{16{imm[15]}}, imm};
        zext    = {16'b0, imm};
        d.legal = 1'b1;
        d.ctrl  = 4'b0000;
        d.a     = rs;
        d.b     = rt;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: d.ctrl = 4'b0010;
                    6'h21: d.ctrl = 4'b1000;
                    6'h22: d.ctrl = 4'b0110;
                    6'h23: d.ctrl = 4'b1001;
                    6'h24: d.ctrl = 4'b0000;
                    6'h25: d.ctrl = 4'b0001;
                    6'h26: d.ctrl = 4'b1010;
                    6'h27: d.ctrl = 4'b1100;
                    6'h2A: d.ctrl = 4'b0111;
                    6'h2B: d.ctrl = 4'b1011;
                    // Shifts operate on rt by the shamt field
                    6'h00: begin d.ctrl = 4'b0011; d.a = rt; d.b = {27'b0, sh}; end
                    6'h02: begin d.ctrl = 4'b0100; d.a = rt; d.b = {27'b0, sh}; end
                    6'h03: begin d.ctrl = 4'b1101; d.a = rt; d.b = {27'b0, sh}; end
                    default: d.legal = 1'b0;
                endcase
            end
            6'h08: begin d.ctrl = 4'b0010; d.b = sext; end
            6'h09: begin d.ctrl = 4'b1000; d.b = sext; end
            6'h0A: begin d.ctrl = 4'b0111; d.b = sext; end
            6'h0B: begin d.ctrl = 4'b1011; d.b = sext; end
            6'h0C: begin d.ctrl = 4'b0000; d.b = zext; end
            6'h0D: begin d.ctrl = 4'b0001; d.b = zext; end
            6'h0E: begin d.ctrl = 4'b1010; d.b = zext; end
            6'h0F: begin d.ctrl = 4'b1110; d.b = zext; end
            // Branch compare: equality is read from the ALU zero flag
            6'h04, 6'h05: begin d.ctrl = 4'b0110; d.b = rt; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    assign ReqReady  = (state == IDLE) & ~Reset;
    assign accept    = ReqValid & ReqReady;
    assign RespValid = (state == RESP);
    assign dec       = decode(Opcode, Funct, Shamt, RsData, RtData, Imm);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = dec.legal ? WAIT : RESP;
            WAIT: if (waitCnt == LAST_WAIT) stateNext = RESP;
            RESP: if (RespReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Issue stage: operands latched on accept, response captured after settle
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ALUCtrl    <= 4'b0;
            BusA       <= 32'b0;
            BusB       <= 32'b0;
            Result     <= 32'b0;
            ResultZero <= 1'b0;
            IllegalOp  <= 1'b0;
            waitCnt    <= 4'b0;
        end else begin
            if (accept) begin
                if (dec.legal) begin
                    ALUCtrl <= dec.ctrl;
                    BusA    <= dec.a;
                    BusB    <= dec.b;
                    waitCnt <= 4'b0;
                end else begin
                    // Illegal ops skip the ALU entirely; its inputs keep the last op
                    IllegalOp  <= 1'b1;
                    Result     <= 32'b0;
                    ResultZero <= 1'b0;
                end
            end
            if (state == WAIT) begin
                if (waitCnt == LAST_WAIT) begin
                    Result     <= BusW;
                    ResultZero <= Zero;
                    IllegalOp  <= 1'b0;
                end else begin
                    waitCnt <= waitCnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU
// attached to ALUCtrl/BusA/BusB -> BusW/Zero.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int SETTLE = 3;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [4:0]  Shamt;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [15:0] Imm;
    logic [3:0]  ALUCtrl;
    logic [31:0] BusA;
    logic [31:0] BusB;
    logic [31:0] BusW;
    logic        Zero;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] Result;
    logic        ResultZero;
    logic        IllegalOp;

    int errors = 0;
    int checks = 0;

    alu_issue_ctrl #(.SETTLE(SETTLE)) dut (
        .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Opcode(Opcode), .Funct(Funct), .Shamt(Shamt), .RsData(RsData),
        .RtData(RtData), .Imm(Imm), .ALUCtrl(ALUCtrl), .BusA(BusA), .BusB(BusB),
        .BusW(BusW), .Zero(Zero), .RespValid(RespValid), .RespReady(RespReady),
        .Result(Result), .ResultZero(ResultZero), .IllegalOp(IllegalOp)
    );

    always #5 CLK = ~CLK;

    // Behavioural MIPS ALU
    always_comb begin
        case (ALUCtrl)
            4'b0000: BusW = BusA & BusB;
            4'b0001: BusW = BusA | BusB;
            4'b0010: BusW = BusA + BusB;
            4'b0110: BusW = BusA - BusB;
            4'b0111: BusW = {31'b0, $signed(BusA) < $signed(BusB)};
            4'b1000: BusW = BusA + BusB;
            4'b1001: BusW = BusA - BusB;
            4'b1010: BusW = BusA ^ BusB;
            4'b1011: BusW = {31'b0, BusA < BusB};
            4'b1100: BusW = ~(BusA | BusB);
            4'b0011: BusW = BusA << BusB[4:0];
            4'b0100: BusW = BusA >> BusB[4:0];
            4'b1101: BusW = $unsigned($signed(BusA) >>> BusB[4:0]);
            4'b1110: BusW = BusB << 16;
            default: BusW = 32'b0;
        endcase
        Zero = (BusW == 32'b0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request; returns after the accept edge
    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        Opcode = op; Funct = fn; Shamt = sh; RsData = rs; RtData = rt; Imm = imm;
        ReqValid = 1'b1;
        tick();
        ReqValid = 1'b0;
    endtask

    // Count edges after accept until RespValid; checks the latency
    task automatic waitResp(input string tag, input int expLat);
        int lat;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (RespValid) begin
                lat = i;
                break;
            end
            tick();
        end
        chk(tag, 32'(lat), 32'(expLat));
    endtask

    task automatic handshake(input string tag);
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
        chk({tag, "_respdrop"}, {31'b0, RespValid}, 32'd0);
        chk({tag, "_readyback"}, {31'b0, ReqReady}, 32'd1);
    endtask

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; RespReady = 1'b0;
        Opcode = 6'h0; Funct = 6'h0; Shamt = 5'h0; RsData = 32'h0; RtData = 32'h0; Imm = 16'h0;
        tick();
        tick();
        chk("rst_reqready", {31'b0, ReqReady}, 32'd0);
        chk("rst_respvalid", {31'b0, RespValid}, 32'd0);
        chk("rst_aluctrl", {28'b0, ALUCtrl}, 32'd0);
        chk("rst_busa", BusA, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_illegal", {31'b0, IllegalOp}, 32'd0);
        Reset = 1'b0;
        #1;
        chk("idle_reqready", {31'b0, ReqReady}, 32'd1);

        // ADD 5 + 7
        issue(6'h00, 6'h20, 5'd0, 32'd5, 32'd7, 16'h0);
        chk("add_aluctrl", {28'b0, ALUCtrl}, 32'h2);
        chk("add_busa", BusA, 32'd5);
        chk("add_busb", BusB, 32'd7);
        chk("add_reqready_busy", {31'b0, ReqReady}, 32'd0);
        waitResp("add_latency", SETTLE);
        chk("add_result", Result, 32'd12);
        chk("add_zero", {31'b0, ResultZero}, 32'd0);
        chk("add_illegal", {31'b0, IllegalOp}, 32'd0);
        handshake("add");

        // BEQ equal operands
        issue(6'h04, 6'h00, 5'd0, 32'h1234, 32'h1234, 16'h0010);
        chk("beq_aluctrl", {28'b0, ALUCtrl}, 32'h6);
        chk("beq_busb", BusB, 32'h1234);
        waitResp("beq_latency", SETTLE);
        chk("beq_result", Result, 32'd0);
        chk("beq_zero", {31'b0, ResultZero}, 32'd1);
        handshake("beq");

        // ADDI with sign-extended -1
        issue(6'h08, 6'h3F, 5'd0, 32'd1, 32'h0, 16'hFFFF);
        chk("addi_busb", BusB, 32'hFFFF_FFFF);
        waitResp("addi_latency", SETTLE);
        chk("addi_result", Result, 32'd0);
        chk("addi_zero", {31'b0, ResultZero}, 32'd1);
        handshake("addi");

        // ORI zero-extends
        issue(6'h0D, 6'h00, 5'd0, 32'h1234_0000, 32'h0, 16'hFFFF);
        chk("ori_aluctrl", {28'b0, ALUCtrl}, 32'h1);
        chk("ori_busb", BusB, 32'h0000_FFFF);
        waitResp("ori_latency", SETTLE);
        chk("ori_result", Result, 32'h1234_FFFF);
        handshake("ori");

        // LUI
        issue(6'h0F, 6'h00, 5'd0, 32'h0, 32'h0, 16'hABCD);
        chk("lui_aluctrl", {28'b0, ALUCtrl}, 32'hE);
        chk("lui_busb", BusB, 32'h0000_ABCD);
        waitResp("lui_latency", SETTLE);
        chk("lui_result", Result, 32'hABCD_0000);
        handshake("lui");

        // SLTIU with sign-extended immediate compares unsigned: 5 < 0xFFFFFFFF
        issue(6'h0B, 6'h00, 5'd0, 32'd5, 32'h0, 16'hFFFF);
        chk("sltiu_aluctrl", {28'b0, ALUCtrl}, 32'hB);
        chk("sltiu_busb", BusB, 32'hFFFF_FFFF);
        waitResp("sltiu_latency", SETTLE);
        chk("sltiu_result", Result, 32'd1);
        handshake("sltiu");

        // SLT signed: -1 < 1
        issue(6'h00, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0);
        chk("slt_aluctrl", {28'b0, ALUCtrl}, 32'h7);
        waitResp("slt_latency", SETTLE);
        chk("slt_result", Result, 32'd1);
        handshake("slt");

        // SRA by 4
        issue(6'h00, 6'h03, 5'd4, 32'h55, 32'h8000_0000, 16'h0);
        chk("sra_aluctrl", {28'b0, ALUCtrl}, 32'hD);
        chk("sra_busa", BusA, 32'h8000_0000);
        chk("sra_busb", BusB, 32'd4);
        waitResp("sra_latency", SETTLE);
        chk("sra_result", Result, 32'hF800_0000);
        handshake("sra");

        // Illegal opcode: immediate response, ALU regs keep SRA values
        issue(6'h3F, 6'h20, 5'd1, 32'd9, 32'd9, 16'h1);
        waitResp("ill_latency", 0);
        chk("ill_flag", {31'b0, IllegalOp}, 32'd1);
        chk("ill_result", Result, 32'd0);
        chk("ill_zero", {31'b0, ResultZero}, 32'd0);
        chk("ill_aluctrl_hold", {28'b0, ALUCtrl}, 32'hD);
        chk("ill_busa_hold", BusA, 32'h8000_0000);
        chk("ill_busb_hold", BusB, 32'd4);
        handshake("ill");
        chk("ill_flag_after", {31'b0, IllegalOp}, 32'd1);

        // Illegal funct under opcode 0
        issue(6'h00, 6'h01, 5'd0, 32'd1, 32'd2, 16'h0);
        waitResp("illfn_latency", 0);
        chk("illfn_flag", {31'b0, IllegalOp}, 32'd1);
        handshake("illfn");

        // Backpressure: response held, new requests ignored
        issue(6'h00, 6'h20, 5'd0, 32'd10, 32'd20, 16'h0);
        waitResp("bp_latency", SETTLE);
        chk("bp_illegal_clear", {31'b0, IllegalOp}, 32'd0);
        Opcode = 6'h00; Funct = 6'h22; RsData = 32'd100; RtData = 32'd1;
        ReqValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_respvalid", {31'b0, RespValid}, 32'd1);
            chk("bp_result", Result, 32'd30);
            chk("bp_reqready", {31'b0, ReqReady}, 32'd0);
        end
        chk("bp_aluctrl_hold", {28'b0, ALUCtrl}, 32'h2);
        chk("bp_busa_hold", BusA, 32'd10);
        ReqValid = 1'b0;
        handshake("bp");
        chk("bp_result_after", Result, 32'd30);

        // Reset pulse while waiting for the ALU
        issue(6'h00, 6'h22, 5'd0, 32'd9, 32'd4, 16'h0);
        tick();
        Reset = 1'b1;
        #1;
        chk("rw_respvalid", {31'b0, RespValid}, 32'd0);
        chk("rw_aluctrl", {28'b0, ALUCtrl}, 32'd0);
        chk("rw_busa", BusA, 32'd0);
        chk("rw_busb", BusB, 32'd0);
        chk("rw_result", Result, 32'd0);
        chk("rw_reqready", {31'b0, ReqReady}, 32'd0);
        tick();
        Reset = 1'b0;
        #1;
        chk("rw_reqready_after", {31'b0, ReqReady}, 32'd1);
        for (int i = 0; i < SETTLE + 2; i++) begin
            tick();
            chk("rw_no_resp", {31'b0, RespValid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
